bsr_chain: RTL and testbench

Parametrised boundary-scan register chain sitting between device pads and core logic. It is the generalisation of the per-pin capture/shift/update cell arrangement. The chain:
- instantiates NUM_IN input cells and NUM_OUT output cells as one serial register between `tdi` and `tdo`;
- is driven by the strobes from `jtag_test_logic`;
- in test mode, isolates the core from the pads (EXTEST/INTEST style), with an optional output-enable control cell.

---
 rtl/bsr_chain.sv | 78 +++++++
 tb/tb_bsr_chain.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_chain.sv
// bsr_chain: parametrised boundary-scan register chain between pads and core.
// Each cell has a shift stage (sr_q) and an update stage (upd_q). Bit 0 is
// nearest tdi; input cells come first, then output cells, then the optional
// output-enable cell (macro BSR_OE_CELL_EN) at the tdo end.
module bsr_chain #(
   parameter int unsigned NUM_IN  = 3,
   parameter int unsigned NUM_OUT = 2
) (
   input  logic               tck,
   input  logic               trst,
   input  logic               tdi,
   output logic               tdo,
   input  logic               capture_dr,
   input  logic               shift_dr,
   input  logic               update_dr,
   input  logic               mode,
   input  logic [NUM_IN-1:0]  pad_in,
   output logic [NUM_IN-1:0]  core_in,
   input  logic [NUM_OUT-1:0] core_out,
`ifdef BSR_OE_CELL_EN
   output logic               pad_oe,
`endif
   output logic [NUM_OUT-1:0] pad_out
);

`ifdef BSR_OE_CELL_EN
   localparam int unsigned L = NUM_IN + NUM_OUT + 1;
`else
   localparam int unsigned L = NUM_IN + NUM_OUT;
`endif

   logic [L-1:0] sr_q, sr_d;
   logic [L-1:0] upd_q, upd_d;

   // Next shift-stage value: capture has priority over shift, otherwise hold.
   always_comb begin
      sr_d = sr_q;
      if (capture_dr) begin
         sr_d[NUM_IN-1:0]         = pad_in;
         sr_d[NUM_IN +: NUM_OUT]  = core_out;
`ifdef BSR_OE_CELL_EN
         sr_d[L-1]                = upd_q[L-1];
`endif
      end else if (shift_dr) begin
         sr_d = {sr_q[L-2:0], tdi};
      end
   end

   // Next update-stage value: latch the pre-edge shift stage on update_dr.
   always_comb begin
      upd_d = upd_q;
      if (update_dr) begin
         upd_d = sr_q;
      end
   end

   // Shift and update registers, cleared asynchronously by trst.
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         sr_q  <= '0;
         upd_q <= '0;
      end else begin
         sr_q  <= sr_d;
         upd_q <= upd_d;
      end
   end

   // Serial output and mode-selected parallel muxes.
   always_comb begin
      tdo     = sr_q[L-1];
      core_in = mode ? upd_q[NUM_IN-1:0]        : pad_in;
      pad_out = mode ? upd_q[NUM_IN +: NUM_OUT] : core_out;
`ifdef BSR_OE_CELL_EN
      pad_oe  = mode ? upd_q[L-1] : 1'b1;
`endif
   end

endmodule

// File: tb/tb_bsr_chain.sv
// Self-checking bench for bsr_chain: directed steps plus randomized strobes,
// compared against a queue-based model of the scan chain.
module tb_bsr_chain;

   localparam int unsigned NUM_IN  = 3;
   localparam int unsigned NUM_OUT = 2;
`ifdef BSR_OE_CELL_EN
   localparam int unsigned L = NUM_IN + NUM_OUT + 1;
`else
   localparam int unsigned L = NUM_IN + NUM_OUT;
`endif

   logic               tck = 1'b0;
   logic               trst;
   logic               tdi;
   logic               tdo;
   logic               capture_dr;
   logic               shift_dr;
   logic               update_dr;
   logic               mode;
   logic [NUM_IN-1:0]  pad_in;
   logic [NUM_IN-1:0]  core_in;
   logic [NUM_OUT-1:0] core_out;
   logic [NUM_OUT-1:0] pad_out;
`ifdef BSR_OE_CELL_EN
   logic               pad_oe;
`endif

   int checks = 0;
   int errors = 0;

   // Model: chain as a queue, index 0 nearest tdi; update stage as a bit array.
   bit sr_m[$];
   bit upd_m[L];

   always #5 tck = ~tck;

   bsr_chain #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
      .tck(tck), .trst(trst), .tdi(tdi), .tdo(tdo),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .mode(mode), .pad_in(pad_in), .core_in(core_in),
      .core_out(core_out),
`ifdef BSR_OE_CELL_EN
      .pad_oe(pad_oe),
`endif
      .pad_out(pad_out)
   );

   task automatic model_reset();
      sr_m = {};
      for (int k = 0; k < L; k++) begin
         sr_m.push_back(1'b0);
         upd_m[k] = 1'b0;
      end
   endtask

   // Compute next model state from pre-edge inputs, then advance one edge.
   task automatic tick();
      bit nsr[$];
      bit nupd[L];
      if (capture_dr) begin
         nsr = {};
         for (int i = 0; i < NUM_IN; i++)  nsr.push_back(pad_in[i]);
         for (int j = 0; j < NUM_OUT; j++) nsr.push_back(core_out[j]);
`ifdef BSR_OE_CELL_EN
         nsr.push_back(upd_m[L-1]);
`endif
      end else if (shift_dr) begin
         nsr = sr_m;
         nsr.push_front(tdi);
         void'(nsr.pop_back());
      end else begin
         nsr = sr_m;
      end
      for (int k = 0; k < L; k++) nupd[k] = update_dr ? sr_m[k] : upd_m[k];
      @(posedge tck);
      #1;
      sr_m  = nsr;
      upd_m = nupd;
   endtask

   task automatic check(input string tag);
      logic [NUM_IN-1:0]  ci_exp;
      logic [NUM_OUT-1:0] po_exp;
      for (int i = 0; i < NUM_IN; i++)  ci_exp[i] = mode ? upd_m[i] : pad_in[i];
      for (int j = 0; j < NUM_OUT; j++) po_exp[j] = mode ? upd_m[NUM_IN+j] : core_out[j];
      checks++;
      assert (tdo === sr_m[L-1]) else begin
         errors++;
         $error("FAIL %s tdo: observed %0b expected %0b", tag, tdo, sr_m[L-1]);
      end
      checks++;
      assert (core_in === ci_exp) else begin
         errors++;
         $error("FAIL %s core_in: observed %b expected %b", tag, core_in, ci_exp);
      end
      checks++;
      assert (pad_out === po_exp) else begin
         errors++;
         $error("FAIL %s pad_out: observed %b expected %b", tag, pad_out, po_exp);
      end
`ifdef BSR_OE_CELL_EN
      checks++;
      assert (pad_oe === (mode ? upd_m[L-1] : 1'b1)) else begin
         errors++;
         $error("FAIL %s pad_oe: observed %b expected %b", tag, pad_oe,
                (mode ? upd_m[L-1] : 1'b1));
      end
`endif
   endtask

   task automatic idle();
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
   endtask

   // Shift a vector in MSB first so that bit k ends in cell k.
   task automatic shift_vec(input logic [L-1:0] v);
      idle();
      shift_dr = 1'b1;
      for (int k = L - 1; k >= 0; k--) begin
         tdi = v[k];
         tick();
         check("shift_vec");
      end
      idle();
   endtask

   initial begin
      logic [L-1:0] pre;
      trst = 1'b0;
      tdi  = 1'b0;
      idle();
      mode     = 1'b1;
      pad_in   = 3'b111;
      core_out = 2'b11;
      model_reset();
      #12;
      check("reset_mode1");
      checks++;
      assert (core_in === 3'b000 && pad_out === 2'b00 && tdo === 1'b0) else begin
         errors++;
         $error("FAIL reset_const: observed %b/%b/%b expected 000/00/0", core_in, pad_out, tdo);
      end
      @(negedge tck);
      trst = 1'b1;
      tick();
      check("after_release");

      // Transparent path.
      mode     = 1'b0;
      pad_in   = 3'b101;
      core_out = 2'b10;
      #1;
      check("transparent");
      shift_vec(5'b10110);
      check("transparent_after_scan");

      // Capture then shift out.
      pad_in   = 3'b110;
      core_out = 2'b01;
      capture_dr = 1'b1;
      shift_dr   = 1'b1;         // capture wins over shift
      tick();
      idle();
      check("capture");
      shift_dr = 1'b1;
      tdi      = 1'b0;
      for (int n = 0; n < L; n++) begin
         tick();
         check("shift_out");
      end
      idle();

      // Preload and update, then test mode.
      pre = '0;
      pre[4:0] = 5'b11010;
      shift_vec(pre);
      update_dr = 1'b1;
      tick();
      idle();
      mode = 1'b1;
      #1;
      check("preload_mode1");
`ifndef BSR_OE_CELL_EN
      checks++;
      assert (pad_out === 2'b11 && core_in === 3'b010) else begin
         errors++;
         $error("FAIL preload_const: observed %b/%b expected 11/010", pad_out, core_in);
      end
`endif
      mode = 1'b0;
      #1;
      check("preload_mode0");
      mode = 1'b1;
      #1;
      check("mode_persist");

      // Update and shift on the same edge.
      shift_dr  = 1'b1;
      update_dr = 1'b1;
      tdi       = 1'b1;
      tick();
      idle();
      check("update_with_shift");

      // Randomized strobes and data.
      for (int n = 0; n < 300; n++) begin
         capture_dr = ($urandom_range(0, 7) == 0);
         shift_dr   = ($urandom_range(0, 3) != 0);
         update_dr  = ($urandom_range(0, 5) == 0);
         tdi        = 1'($urandom);
         mode       = 1'($urandom);
         pad_in     = NUM_IN'($urandom);
         core_out   = NUM_OUT'($urandom);
         #1;
         check("random_pre");
         tick();
         check("random");
      end

      // OE-cell style preload with OE bit cleared, then reset mid-shift.
      pre = '1;
      pre[L-1] = 1'b0;
      mode = 1'b1;
      shift_vec(pre);
      update_dr = 1'b1;
      tick();
      idle();
      check("oe_clear");
      shift_dr = 1'b1;
      tdi      = 1'b1;
      tick();
      tick();
      trst = 1'b0;
      model_reset();
      #1;
      check("reset_mid_shift");
      mode = 1'b0;
      #1;
      check("reset_mode0");
      @(negedge tck);
      trst = 1'b1;
      tick();
      check("restart");
      idle();
      tick();
      check("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
